// File: rtl/pdm_stereo_decimator.sv
// Stereo PDM front end: shared mic clock, left/right capture on opposite clock
// edges, per-channel CIC decimator and a 2-entry output FIFO with a sticky overflow flag.
module pdm_stereo_decimator #(
  parameter int INPUT_FREQ = 100000000,
  parameter int PDM_FREQ   = 3125000,
  parameter int DECIM      = 16,
  parameter int ORDER      = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 mic_clk,
  input  logic                 mic_pdm_data,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic                 m_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 overflow
);

  localparam int DIV   = INPUT_FREQ / PDM_FREQ;
  localparam int HALF  = DIV / 2;
  localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LOG_R = $clog2(DECIM);
  localparam int W     = 2 + ORDER * LOG_R;
  localparam int SW    = $clog2(ORDER + 1);

  typedef logic [W-1:0]         acc_t;
  typedef logic [OUT_WIDTH:0]   entry_t;  // {tdata, tuser}

  logic [1:0]          sync_q;
  logic                run_q;
  logic                mic_clk_q;
  logic [HW-1:0]       div_q;
  acc_t                integ_q    [2][ORDER];
  acc_t                comb_dly_q [2][ORDER];
  logic [LOG_R-1:0]    dec_cnt_q  [2];
  logic [SW-1:0]       settle_q   [2];
  logic                stb1_q, ch1_q;
  logic                stb2_q, ch2_q;
  logic [OUT_WIDTH-1:0] res_q;
  entry_t              fifo_q     [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;
  logic                overflow_q;

  logic [1:0] cap;
  acc_t       step;
  acc_t       integ_d [2][ORDER];
  acc_t       comb_in [ORDER];
  acc_t       comb_out;
  logic       push, pop, push_ok, full;

  // cap[0]: mic_clk about to fall (left), cap[1]: about to rise again (right).
  assign cap[0] = run_q &&  mic_clk_q && (div_q == HW'(HALF - 1));
  assign cap[1] = run_q && !mic_clk_q && (div_q == HW'(HALF - 1));
  assign step   = sync_q[1] ? acc_t'(1) : '1;

  // NOTE: acc is a blocking temporary inside combinational logic; it never holds state.
  always_comb begin
    acc_t acc;
    acc = step;
    for (int c = 0; c < 2; c++) begin
      acc = step;
      for (int k = 0; k < ORDER; k++) begin
        acc           = integ_q[c][k] + acc;
        integ_d[c][k] = acc;
      end
    end
  end

  always_comb begin
    acc_t acc;
    acc = integ_q[ch1_q][ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = acc;
      acc        = acc - comb_dly_q[ch1_q][k];
    end
    comb_out = acc;
  end

  if (W > OUT_WIDTH) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^comb_out[W-OUT_WIDTH-1:0];
  end

  assign full    = (count_q == 2'd2);
  assign push    = stb2_q;
  assign pop     = (count_q != 2'd0) && m_tready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      // NOTE: the FIFO and filter arrays are plain registers, so they clear with the rest.
      run_q      <= 1'b0;
      mic_clk_q  <= 1'b0;
      div_q      <= '0;
      stb1_q     <= 1'b0;
      ch1_q      <= 1'b0;
      stb2_q     <= 1'b0;
      ch2_q      <= 1'b0;
      res_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        dec_cnt_q[c] <= '0;
        settle_q[c]  <= '0;
        fifo_q[c]    <= '0;
        for (int k = 0; k < ORDER; k++) begin
          integ_q[c][k]    <= '0;
          comb_dly_q[c][k] <= '0;
        end
      end
      sync_q <= reset ? 2'b00 : {sync_q[0], mic_pdm_data};
    end else begin
      sync_q <= {sync_q[0], mic_pdm_data};

      if (!run_q) begin
        run_q     <= 1'b1;
        mic_clk_q <= 1'b1;
        div_q     <= '0;
      end else if (div_q == HW'(HALF - 1)) begin
        div_q     <= '0;
        mic_clk_q <= !mic_clk_q;
      end else begin
        div_q <= div_q + 1'b1;
      end

      stb1_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (cap[c]) begin
          for (int k = 0; k < ORDER; k++) integ_q[c][k] <= integ_d[c][k];
          dec_cnt_q[c] <= dec_cnt_q[c] + 1'b1;
          if (dec_cnt_q[c] == '1) begin
            stb1_q <= 1'b1;
            ch1_q  <= 1'(c);
          end
        end
      end

      // Comb stage; the first ORDER results per channel only prime the delays.
      stb2_q <= 1'b0;
      if (stb1_q) begin
        for (int k = 0; k < ORDER; k++) comb_dly_q[ch1_q][k] <= comb_in[k];
        res_q <= comb_out[W-1 -: OUT_WIDTH];
        ch2_q <= ch1_q;
        if (settle_q[ch1_q] == SW'(ORDER)) stb2_q <= 1'b1;
        else settle_q[ch1_q] <= settle_q[ch1_q] + 1'b1;
      end

      if (pop) rd_ptr_q <= !rd_ptr_q;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= {res_q, ch2_q};
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (push && !push_ok) overflow_q <= 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 2'd1;
      else if (!push_ok && pop) count_q <= count_q - 2'd1;
    end
  end

  assign mic_clk             = mic_clk_q;
  assign {m_tdata, m_tuser}  = fifo_q[rd_ptr_q];
  assign m_tvalid            = (count_q != 2'd0);
  assign overflow            = overflow_q;

endmodule
